// File: rtl/usr_irq_resp_if.sv
// Request/response and host-message signals of the user interrupt responder.
// master drives requests and msg_rdy; slave is the responder.
interface usr_irq_resp_if;
    logic [11:0] usr_irq_in_vec;
    logic [7:0]  usr_irq_in_fnc;
    logic        usr_irq_in_vld;
    logic        usr_irq_out_ack;
    logic        usr_irq_out_fail;
    logic [11:0] msg_vec;
    logic [7:0]  msg_fnc;
    logic        msg_vld;
    logic        msg_rdy;

    modport master (
        output usr_irq_in_vec,
        output usr_irq_in_fnc,
        output usr_irq_in_vld,
        output msg_rdy,
        input  usr_irq_out_ack,
        input  usr_irq_out_fail,
        input  msg_vec,
        input  msg_fnc,
        input  msg_vld
    );

    modport slave (
        input  usr_irq_in_vec,
        input  usr_irq_in_fnc,
        input  usr_irq_in_vld,
        input  msg_rdy,
        output usr_irq_out_ack,
        output usr_irq_out_fail,
        output msg_vec,
        output msg_fnc,
        output msg_vld
    );
endinterface

// File: rtl/usr_irq_resp.sv
// User interrupt responder: validates a request, forwards it to the host
// side, and returns exactly one ack or fail pulse per request.
module usr_irq_resp #(
    parameter int NUM_FNC = 4,
    parameter int VEC_MAX = 31,
    parameter int ACK_LAT = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    usr_irq_resp_if.slave      irq,
    input  logic [NUM_FNC-1:0] fnc_en,
    output logic               busy,
    output logic [15:0]        ack_cnt,
    output logic [15:0]        fail_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DELIVER,
        LAT,
        RESP,
        DRAIN
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [3:0]  lat_cnt;
    logic [7:0]  wait_cnt;
    logic        ok_q;
    logic        drop_q;
    logic        vld;
    logic        hs;
    logic        tmo;
    logic        req_ok;

    assign vld = irq.usr_irq_in_vld;
    assign hs  = (state == DELIVER) && irq.msg_rdy;
    assign tmo = (wait_cnt == 8'(TIMEOUT - 1));

    // Out-of-range function numbers match no enable bit and fail.
    always_comb begin
        req_ok = 1'b0;
        for (int i = 0; i < NUM_FNC; i++) begin
            if (irq.msg_fnc == 8'(i)) req_ok = fnc_en[i];
        end
        if (32'(irq.msg_vec) > 32'(VEC_MAX)) req_ok = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (vld) nxt = CHECK;
            CHECK: begin
                if (!vld)         nxt = IDLE;
                else if (!req_ok) nxt = RESP;
                else              nxt = DELIVER;
            end
            // An abandoned request still finishes its message, silently.
            DELIVER: begin
                if (hs || tmo) begin
                    if (drop_q || !vld)    nxt = IDLE;
                    else if (!hs)          nxt = RESP;
                    else if (ACK_LAT == 0) nxt = RESP;
                    else                   nxt = LAT;
                end
            end
            LAT: begin
                if (!vld)                nxt = IDLE;
                else if (lat_cnt == 4'd1) nxt = RESP;
            end
            RESP:    nxt = DRAIN;
            DRAIN:   if (!vld) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        irq.usr_irq_out_ack  = !rst && (state == RESP) && ok_q;
        irq.usr_irq_out_fail = !rst && (state == RESP) && !ok_q;
        irq.msg_vld          = !rst && (state == DELIVER);
        busy                 = !rst && (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq.msg_vec <= '0;
            irq.msg_fnc <= '0;
            lat_cnt     <= '0;
            wait_cnt    <= '0;
            ok_q        <= 1'b0;
            drop_q      <= 1'b0;
            ack_cnt     <= '0;
            fail_cnt    <= '0;
        end else begin
            if (state == IDLE && vld) begin
                irq.msg_vec <= irq.usr_irq_in_vec;
                irq.msg_fnc <= irq.usr_irq_in_fnc;
            end
            if (state == CHECK) begin
                ok_q     <= 1'b0;
                drop_q   <= 1'b0;
                wait_cnt <= '0;
            end
            if (state == DELIVER) begin
                if (!vld) drop_q <= 1'b1;
                if (!hs)  wait_cnt <= wait_cnt + 8'd1;
                ok_q    <= hs;
                lat_cnt <= 4'(ACK_LAT);
            end
            if (state == LAT) lat_cnt <= lat_cnt - 4'd1;
            if (irq.usr_irq_out_ack && ack_cnt != 16'hFFFF)
                ack_cnt <= ack_cnt + 16'd1;
            if (irq.usr_irq_out_fail && fail_cnt != 16'hFFFF)
                fail_cnt <= fail_cnt + 16'd1;
        end
    end

endmodule

// File: doc/usr_irq_resp.md
USR_IRQ_RESP -- requirements
Module: usr_irq_resp

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
  - NUM_FNC, 4: number of valid PCIe functions.
  - VEC_MAX, 31: highest legal vector number.
  - ACK_LAT, 4: cycles from message handshake to response; range 0..15.
  - TIMEOUT, 15: maximum msg_vld cycles without msg_rdy; range 1..255.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
  - clk, in, 1: single clock; all logic on its rising edge.
  - rst, in, 1: reset; synchronous, active-high.
  - usr_irq_in_vec, in, 12: requested vector.
  - usr_irq_in_fnc, in, 8: requesting function.
  - usr_irq_in_vld, in, 1: request level; held high by the requester until it sees a response.
  - usr_irq_out_ack, out, 1: one-cycle success pulse.
  - usr_irq_out_fail, out, 1: one-cycle failure pulse.
  - fnc_en, in, NUM_FNC: per-function interrupt enable.
  - msg_vec, out, 12: captured vector to host side.
  - msg_fnc, out, 8: captured function to host side.
  - msg_vld, out, 1: message valid.
  - msg_rdy, in, 1: host side accepts the message.
  - busy, out, 1: high whenever state is not IDLE.
  - ack_cnt, out, 16: count of ack pulses.
  - fail_cnt, out, 16: count of fail pulses.

Function
REQ-003 The FSM SHALL have exactly six states: IDLE, CHECK, DELIVER, LAT, RESP, DRAIN.
REQ-004 In IDLE with usr_irq_in_vld=1, the block SHALL capture vec/fnc into msg_vec/msg_fnc and go to CHECK; the captured values SHALL stay stable until the next capture.
REQ-005 CHECK SHALL last one cycle; it SHALL go to RESP with failure if fnc>=NUM_FNC, fnc_en[fnc]=0, or vec>VEC_MAX, and to DELIVER otherwise.
REQ-006 msg_vld SHALL be high exactly while in DELIVER; a handshake occurs in a cycle with msg_vld=1 and msg_rdy=1.
REQ-007 On handshake, the FSM SHALL go to RESP with success if ACK_LAT=0; otherwise it SHALL load a 4-bit counter with ACK_LAT and enter LAT.
REQ-008 LAT SHALL decrement the counter each cycle and go to RESP with success in the cycle the counter equals 1; the ack is therefore high in cycle H+1+ACK_LAT, where H is the handshake cycle.
REQ-009 In DELIVER, an 8-bit wait counter SHALL start at 0 and increment each cycle without handshake; when it reaches TIMEOUT, msg_vld SHALL drop and the FSM SHALL go to RESP with failure.
REQ-010 RESP SHALL last one cycle, asserting exactly one of usr_irq_out_ack or usr_irq_out_fail, then go to DRAIN.
REQ-011 DRAIN SHALL stay until usr_irq_in_vld=0, then go to IDLE; a request therefore SHALL never receive two responses.
REQ-012 If usr_irq_in_vld drops in CHECK or LAT, the FSM SHALL go to IDLE with no response and no counter change.
REQ-013 If usr_irq_in_vld drops in DELIVER, msg_vld SHALL be held until handshake or timeout, then the FSM SHALL go to IDLE with no response.
REQ-014 The drop checks of REQ-012/REQ-013 SHALL take priority over LAT completion in the same cycle.
REQ-015 ack_cnt and fail_cnt SHALL increment on each respective pulse and saturate at 16'hFFFF.
REQ-016 fnc_en SHALL be sampled only in CHECK; later changes SHALL not affect a request in flight.
REQ-017 ack and fail SHALL never be high in the same cycle.

Reset
REQ-018 While rst=1, state SHALL be IDLE; usr_irq_out_ack, usr_irq_out_fail, msg_vld and busy SHALL be 0; msg_vec, msg_fnc, ack_cnt, fail_cnt and all internal counters SHALL be 0.
REQ-019 rst asserted in any state SHALL abort the request on the next edge with no pulse emitted; the first request may be accepted in the cycle after rst falls.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - vec=5, fnc=1, fnc_en=4'b0010, msg_rdy=1 constant, vld rising in cycle 0 -> msg_vld in cycle 2; ack in cycle 7; ack_cnt=1; busy low once vld drops.
  - vec=40 (>VEC_MAX) -> fail in cycle 2; msg_vld never high; fail_cnt=1.
  - fnc=2 with fnc_en[2]=0 -> fail in cycle 2; fnc=9 -> fail in cycle 2.
  - msg_rdy=0 throughout -> msg_vld high in cycles 2-16; fail in cycle 17.
  - ACK_LAT=0, msg_rdy first high in cycle 5 -> ack in cycle 6.
  - vld held high 10 cycles after ack -> exactly one ack; vld dropped in LAT -> no pulse; rst in LAT -> all outputs 0 next cycle.
  - 65536 ack responses -> ack_cnt stays at 16'hFFFF after the 65535th ack.
